mul_div_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit for the multicycle datapath (MULT, MULTU, DIV, DIVU).
- Sits directly upstream of the HI/LO architectural registers: its hi/lo outputs feed their data inputs, and its one-cycle done pulse drives their write enables.
- Runs a start/busy/done handshake with the main controller, which stalls while busy is high.

---
 rtl/mul_div_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative multiply/divide unit for the multicycle datapath. Executes
// MULT, MULTU, DIV and DIVU one bit per clock. Its hi/lo outputs feed the
// HI/LO architectural registers, and its one-cycle done pulse is their
// write enable. The main controller stalls while busy is high.
//
// An operation takes 34 cycles from the accepting edge:
//   - 1 accept edge
//   - WIDTH iteration edges
//   - 1 sign-adjust edge
// done is high during the final cycle. If start is high in that cycle, the
// next operation is accepted on the same edge that drops done.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        operation request, accepted only while busy is low
//   op           00=MULT, 01=MULTU, 10=DIV, 11=DIVU
//   a            multiplicand / dividend
//   b            multiplier / divisor
//   busy         operation in progress (33 cycles)
//   done         one-cycle pulse, hi/lo/div_by_zero valid
//   hi           product upper word, or remainder
//   lo           product lower word, or quotient
//   div_by_zero  with done: the division had a zero divisor
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADJ,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand conditioning at accept.
  // Signed ops work on magnitudes, and the signs are restored in ADJ.
  // Unsigned ops force both sign flags to 0, so ADJ leaves their
  // results untouched.
  logic             in_signed;
  logic             in_sign_a;
  logic             in_sign_b;
  logic [WIDTH-1:0] in_mag_a;
  logic [WIDTH-1:0] in_mag_b;
  logic             accept;

  assign in_signed = ~op[0];
  assign in_sign_a = in_signed & a[WIDTH-1];
  assign in_sign_b = in_signed & b[WIDTH-1];
  assign in_mag_a  = in_sign_a ? (-a) : a;
  assign in_mag_b  = in_sign_b ? (-b) : b;
  assign accept    = start & ~busy_q;

  // Multiply step.
  // acc holds {partial product, remaining multiplier bits}. When the
  // multiplier LSB is set, the multiplicand is added into the upper
  // half, and the whole thing then shifts right. The adder carry becomes
  // the new MSB after the shift.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step (restoring).
  // The next dividend bit shifts out of the low word into the partial
  // remainder, which needs WIDTH+1 bits at that point. The subtraction
  // is kept only when the divisor fits. The resulting remainder is
  // always below the divisor, so it stores back in WIDTH bits.
  // Quotient bits fill the low word from the right as dividend bits
  // leave it.
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_diff;

  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_fits  = (div_shift >= {1'b0, b_mag_q});
  assign div_diff  = WIDTH'(div_shift - {1'b0, b_mag_q});

  // Sign adjustment applied in ADJ.
  // The remainder follows the dividend's sign. A zero divisor reports
  // the original dividend (magnitude re-signed) and an all-ones quotient.
  // The iteration still runs, so latency is identical.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   dividend_orig;
  logic               dbz_hit;

  assign prod_fix      = (sign_a_q ^ sign_b_q) ? (-acc_q) : acc_q;
  assign quot_fix      = (sign_a_q ^ sign_b_q) ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix       = sign_a_q ? (-rem_q) : rem_q;
  assign dividend_orig = sign_a_q ? (-a_mag_q) : a_mag_q;
  assign dbz_hit       = op_q[1] & (b_mag_q == '0);

  // Next-state and next-output computation.
  // Everything holds by default. Each state only overrides what it
  // changes, so hi/lo are written in ADJ alone and stay stable
  // throughout CALC.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (accept) begin
          op_d     = op;
          a_mag_d  = in_mag_a;
          b_mag_d  = in_mag_b;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          cnt_d    = '0;
          rem_d    = '0;
          // A divide shifts the dividend out of the low word.
          // A multiply shifts the multiplier out of it.
          acc_d    = op[1] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
          dbz_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        if (op_q[1]) begin
          rem_d = div_fits ? div_diff : div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_fits};
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_ADJ;
        end
      end

      ST_ADJ: begin
        if (!op_q[1]) begin
          hi_d  = prod_fix[2*WIDTH-1:WIDTH];
          lo_d  = prod_fix[WIDTH-1:0];
          dbz_d = 1'b0;
        end else if (dbz_hit) begin
          hi_d  = dividend_orig;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d  = rem_fix;
          lo_d  = quot_fix;
          dbz_d = 1'b0;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  // An asynchronous reset clears everything. That includes hi/lo,
  // which aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Self-checking bench for mul_div_unit.
// Each scenario task drives the unit and compares what it sees against
// either constant expected values or a plain-arithmetic reference model
// (64-bit products, SV division/modulo).
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_vec;
  int n_err;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural result computed with plain arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mh, output logic [31:0] ml, output logic mdbz);
    longint          sx;
    longint          sy;
    longint unsigned ux;
    longint unsigned uy;
    logic [63:0]     p;
    sx   = $signed(x);
    sy   = $signed(y);
    ux   = x;
    uy   = y;
    mdbz = 1'b0;
    mh   = '0;
    ml   = '0;
    case (o)
      2'b00: begin p = 64'(sx * sy); mh = p[63:32]; ml = p[31:0]; end
      2'b01: begin p = ux * uy;      mh = p[63:32]; ml = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          mdbz = 1'b1;
          mh   = x;
          ml   = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          ml = 32'(sx / sy);
          mh = 32'(sx % sy);
        end else begin
          ml = x / y;
          mh = x % y;
        end
      end
    endcase
  endfunction

  // Launch one operation and observe it for 36 cycles after the accept
  // edge. Returns what was seen; the caller decides what is correct.
  // poke>0 pulses start with junk operands in that cycle while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int poke,
                        output int busy_cnt, output int done_at, output int done_cnt,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rdbz,
                        output bit moved);
    logic [31:0] h0;
    logic [31:0] l0;
    busy_cnt = 0;
    done_at  = 0;
    done_cnt = 0;
    rh       = '0;
    rl       = '0;
    rdbz     = 1'b0;
    moved    = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    h0    = hi;
    l0    = lo;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (hi !== h0 || lo !== l0) moved = 1'b1;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          rh      = hi;
          rl      = lo;
          rdbz    = div_by_zero;
        end
      end
      start = (k == poke);
      if (k == poke) begin
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
      n_err++;
      $display("[TB] FAIL reset_held: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all 0",
               busy, done, div_by_zero, hi, lo);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
      n_err++;
      $display("[TB] FAIL reset_release: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all 0",
               busy, done, div_by_zero, hi, lo);
    end
  endtask

  // Directed vectors with hand-derived results, including the
  // divide-by-zero clear and the ignored start during the overflow case.
  task automatic test_directed();
    logic [1:0]  t_op  [8];
    logic [31:0] t_a   [8];
    logic [31:0] t_b   [8];
    logic [31:0] t_hi  [8];
    logic [31:0] t_lo  [8];
    logic        t_dbz [8];
    int          t_pk  [8];
    int          bc, da, dc;
    logic [31:0] rh, rl;
    logic        rd;
    bit          mv;
    t_op  = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10};
    t_a   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'd5, 32'd2, 32'h80000000};
    t_b   = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd7, 32'd0, 32'd3, 32'hFFFFFFFF};
    t_hi  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd2, 32'd5, 32'd0, 32'd0};
    t_lo  = '{32'hFFFFFFEB, 32'd1, 32'd1, 32'hFFFFFFFD, 32'hE, 32'hFFFFFFFF, 32'd6, 32'h80000000};
    t_dbz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t_pk  = '{0, 0, 0, 0, 0, 0, 0, 5};
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_pk[i], bc, da, dc, rh, rl, rd, mv);
      n_vec++;
      if (rh !== t_hi[i] || rl !== t_lo[i] || rd !== t_dbz[i]) begin
        n_err++;
        $display("[TB] FAIL directed_result[%0d]: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                 i, rh, rl, rd, t_hi[i], t_lo[i], t_dbz[i]);
      end
      n_vec++;
      if (bc != 33 || da != 34 || dc != 1 || mv) begin
        n_err++;
        $display("[TB] FAIL directed_timing[%0d]: got busy=%0d done_at=%0d dones=%0d hilo_moved=%0d, expected 33/34/1/0",
                 i, bc, da, dc, mv);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [31:0] eh, el;
    logic        ed;
    int          bc, da, dc;
    logic [31:0] rh, rl;
    logic        rd;
    bit          mv;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) rb = 32'hFFFFFFFF;
      if (sel == 2) ra = 32'h80000000;
      if (sel == 3) rb = 32'($urandom_range(1, 15));
      model(ro, ra, rb, eh, el, ed);
      run_op(ro, ra, rb, 0, bc, da, dc, rh, rl, rd, mv);
      n_vec++;
      if (rh !== eh || rl !== el || rd !== ed) begin
        n_err++;
        $display("[TB] FAIL random_result[%0d] op=%b a=%h b=%h: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                 i, ro, ra, rb, rh, rl, rd, eh, el, ed);
      end
      n_vec++;
      if (bc != 33 || da != 34 || dc != 1 || mv) begin
        n_err++;
        $display("[TB] FAIL random_timing[%0d]: got busy=%0d done_at=%0d dones=%0d hilo_moved=%0d, expected 33/34/1/0",
                 i, bc, da, dc, mv);
      end
    end
  endtask

  // start held high across three operations: done every 34 cycles,
  // with the next operands picked up on the edge that ends done.
  task automatic test_back_to_back();
    logic [1:0]  bo [3];
    logic [31:0] ba [3];
    logic [31:0] bb [3];
    logic [31:0] eh, el;
    logic        ed;
    int          idx;
    for (int i = 0; i < 3; i++) begin
      bo[i] = 2'($urandom_range(0, 3));
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    idx = 0;
    @(negedge clk);
    start = 1'b1;
    op    = bo[0];
    a     = ba[0];
    b     = bb[0];
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (idx < 3) begin
          model(bo[idx], ba[idx], bb[idx], eh, el, ed);
          n_vec++;
          if (k != 34 * (idx + 1)) begin
            n_err++;
            $display("[TB] FAIL b2b_timing[%0d]: got done at cycle %0d, expected %0d", idx, k, 34 * (idx + 1));
          end
          n_vec++;
          if (hi !== eh || lo !== el || div_by_zero !== ed) begin
            n_err++;
            $display("[TB] FAIL b2b_result[%0d]: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                     idx, hi, lo, div_by_zero, eh, el, ed);
          end
        end
        idx++;
        if (idx < 3) begin
          op = bo[idx];
          a  = ba[idx];
          b  = bb[idx];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (idx != 3) begin
      n_err++;
      $display("[TB] FAIL b2b_count: got %0d done pulses, expected 3", idx);
    end
  endtask

  task automatic test_reset_mid_op();
    int          bc, da, dc;
    logic [31:0] rh, rl;
    logic        rd;
    bit          mv;
    int          stray;
    logic [31:0] ra, rb;
    logic [31:0] eh, el;
    logic        ed;
    run_op(2'b01, 32'd3, 32'd5, 0, bc, da, dc, rh, rl, rd, mv);
    n_vec++;
    if (rh !== 32'd0 || rl !== 32'd15) begin
      n_err++;
      $display("[TB] FAIL pre_reset_result: got hi=%h lo=%h, expected hi=0 lo=f", rh, rl);
    end
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    a     = $urandom | 32'h1;
    b     = $urandom | 32'h1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL busy_before_reset: got %b, expected 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
      n_err++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all 0",
               busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk);
    rst   = 1'b0;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_vec++;
    if (stray != 0) begin
      n_err++;
      $display("[TB] FAIL no_done_after_abort: got %0d active cycles, expected 0", stray);
    end
    ra = $urandom;
    rb = $urandom;
    model(2'b01, ra, rb, eh, el, ed);
    run_op(2'b01, ra, rb, 0, bc, da, dc, rh, rl, rd, mv);
    n_vec++;
    if (rh !== eh || rl !== el || rd !== ed || da != 34) begin
      n_err++;
      $display("[TB] FAIL post_reset_op: got hi=%h lo=%h dbz=%b done_at=%0d, expected hi=%h lo=%h dbz=%b done_at=34",
               rh, rl, rd, da, eh, el, ed);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    $display("[TB] mul_div_unit bench starting");
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
